// File: rtl/entropy_sequencer.sv
// Frame-level sequencer for the entropy decoder: walks the interleaved MCU block
// order, drives channel/DC-AC phase, handles restart intervals and output backpressure.
module entropy_sequencer #(
  parameter int CH     = 3,
  parameter int MAXBLK = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CH*3-1:0]           cfg_nblk,
  input  logic [15:0]               cfg_num_mcus,
  input  logic [15:0]               cfg_rst_interval,
  input  logic                      huff_valid,
  input  logic                      block_done,
  input  logic                      out_ready,
  input  logic                      marker_done,
  output logic [$clog2(CH+1)-1:0]   ch,
  output logic                      freq,
  output logic                      dec_en,
  output logic                      pred_clear,
  output logic                      marker_req,
  output logic                      busy,
  output logic                      frame_done,
  output logic [15:0]               mcu_idx
);

  localparam int CW = $clog2(CH+1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DC       = 3'd1;
  localparam logic [2:0] S_AC       = 3'd2;
  localparam logic [2:0] S_WAIT_OUT = 3'd3;
  localparam logic [2:0] S_RESTART  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  // Block count of component c, selected without out-of-range part-selects.
  function automatic logic [2:0] nblk_of(input logic [CH*3-1:0] v, input logic [CW-1:0] c);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < CH; i++) begin
      r = (c == CW'(i)) ? v[i*3 +: 3] : r;
    end
    return r;
  endfunction

  // Component 0 always carries at least one block; counts beyond MAXBLK saturate.
  function automatic logic [CH*3-1:0] sanitize_nblk(input logic [CH*3-1:0] v);
    logic [CH*3-1:0] r;
    logic [2:0]      f;
    r = {(CH*3){1'b0}};
    for (int i = 0; i < CH; i++) begin
      f = v[i*3 +: 3];
      f = (int'(f) > MAXBLK) ? 3'(MAXBLK) : f;
      f = ((i == 0) && (f == 3'd0)) ? 3'd1 : f;
      r[i*3 +: 3] = f;
    end
    return r;
  endfunction

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic            freq_q, freq_d;
  logic            dec_en_q, dec_en_d;
  logic            pred_clear_q, pred_clear_d;
  logic            marker_req_q, marker_req_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic [15:0]     mcu_idx_q, mcu_idx_d;
  logic [2:0]      blk_cnt_q, blk_cnt_d;
  logic [15:0]     rst_cnt_q, rst_cnt_d;
  logic [CH*3-1:0] nblk_q, nblk_d;
  logic [15:0]     num_mcus_q, num_mcus_d;
  logic [15:0]     rst_int_q, rst_int_d;

  logic [2:0]      cur_nblk;
  logic            nxt_found;
  logic [CW-1:0]   nxt_ch;
  logic            hit;
  logic            do_adv;

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    busy_d       = busy_q;
    mcu_idx_d    = mcu_idx_q;
    blk_cnt_d    = blk_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    nblk_d       = nblk_q;
    num_mcus_d   = num_mcus_q;
    rst_int_d    = rst_int_q;
    pred_clear_d = 1'b0;
    marker_req_d = 1'b0;
    frame_done_d = 1'b0;
    do_adv       = 1'b0;

    cur_nblk  = nblk_of(nblk_q, ch_q);
    nxt_found = 1'b0;
    nxt_ch    = ch_q;
    hit       = 1'b0;
    // Descending scan so the lowest higher-numbered active component wins.
    for (int i = CH - 1; i >= 0; i--) begin
      hit       = (CW'(i) > ch_q) && (nblk_q[i*3 +: 3] != 3'd0);
      nxt_found = nxt_found | hit;
      nxt_ch    = hit ? CW'(i) : nxt_ch;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nblk_d       = sanitize_nblk(cfg_nblk);
          num_mcus_d   = cfg_num_mcus;
          rst_int_d    = cfg_rst_interval;
          blk_cnt_d    = 3'd0;
          rst_cnt_d    = 16'd0;
          mcu_idx_d    = 16'd0;
          ch_d         = {CW{1'b0}};
          pred_clear_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = S_DC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DC: begin
        if (huff_valid) begin
          state_d = S_AC;
        end else begin
          state_d = S_DC;
        end
      end
      S_AC: begin
        if (block_done) begin
          if (out_ready) begin
            do_adv = 1'b1;
          end else begin
            state_d = S_WAIT_OUT;
          end
        end else begin
          state_d = S_AC;
        end
      end
      S_WAIT_OUT: begin
        if (out_ready) begin
          do_adv = 1'b1;
        end else begin
          state_d = S_WAIT_OUT;
        end
      end
      S_RESTART: begin
        if (marker_done) begin
          pred_clear_d = 1'b1;
          ch_d         = {CW{1'b0}};
          state_d      = S_DC;
        end else begin
          state_d = S_RESTART;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_adv) begin
      if (blk_cnt_q < (cur_nblk - 3'd1)) begin
        blk_cnt_d = blk_cnt_q + 3'd1;
        state_d   = S_DC;
      end else begin
        blk_cnt_d = 3'd0;
        if (nxt_found) begin
          ch_d    = nxt_ch;
          state_d = S_DC;
        end else if ((mcu_idx_q + 16'd1) == num_mcus_q) begin
          frame_done_d = 1'b1;
          state_d      = S_DONE;
        end else if ((rst_int_q != 16'd0) && ((rst_cnt_q + 16'd1) == rst_int_q)) begin
          mcu_idx_d    = mcu_idx_q + 16'd1;
          rst_cnt_d    = 16'd0;
          marker_req_d = 1'b1;
          state_d      = S_RESTART;
        end else begin
          mcu_idx_d = mcu_idx_q + 16'd1;
          rst_cnt_d = rst_cnt_q + 16'd1;
          ch_d      = {CW{1'b0}};
          state_d   = S_DC;
        end
      end
    end else begin
      blk_cnt_d = blk_cnt_d;
    end

    freq_d   = (state_d == S_AC) || (state_d == S_WAIT_OUT);
    dec_en_d = (state_d == S_DC) || (state_d == S_AC);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ch_q         <= {CW{1'b0}};
      freq_q       <= 1'b0;
      dec_en_q     <= 1'b0;
      pred_clear_q <= 1'b0;
      marker_req_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      mcu_idx_q    <= 16'd0;
      blk_cnt_q    <= 3'd0;
      rst_cnt_q    <= 16'd0;
      nblk_q       <= {(CH*3){1'b0}};
      num_mcus_q   <= 16'd0;
      rst_int_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      freq_q       <= freq_d;
      dec_en_q     <= dec_en_d;
      pred_clear_q <= pred_clear_d;
      marker_req_q <= marker_req_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      mcu_idx_q    <= mcu_idx_d;
      blk_cnt_q    <= blk_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      nblk_q       <= nblk_d;
      num_mcus_q   <= num_mcus_d;
      rst_int_q    <= rst_int_d;
    end
  end

  assign ch         = ch_q;
  assign freq       = freq_q;
  assign dec_en     = dec_en_q;
  assign pred_clear = pred_clear_q;
  assign marker_req = marker_req_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign mcu_idx    = mcu_idx_q;

endmodule
